// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read-engine arbiter.
package flash_arb_pkg;

    localparam int ADDR_W    = 24;
    localparam int MAX_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // A zero-length request still fetches one word; long requests stop at one line.
    function automatic logic [3:0] clamp_words(input logic [3:0] words,
                                               input logic [3:0] max_words);
        logic [3:0] result;
        if (words == 4'd0) begin
            result = 4'd1;
        end else if (words > max_words) begin
            result = max_words;
        end else begin
            result = words;
        end
        return result;
    endfunction

endpackage

// File: rtl/flash_arbiter_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words. The completed word is
// presented combinationally on the cycle its fourth byte arrives so the owner
// can register it without an extra stage.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_r;
    logic [23:0] shift_r;

    // Byte position counter and storage for the first three bytes of a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 2'd0;
            shift_r <= 24'd0;
        end else if (clear) begin
            cnt_r   <= 2'd0;
            shift_r <= 24'd0;
        end else if (byte_valid) begin
            cnt_r <= cnt_r + 2'd1;
            case (cnt_r)
                2'd0:    shift_r[7:0]   <= data_byte;
                2'd1:    shift_r[15:8]  <= data_byte;
                2'd2:    shift_r[23:16] <= data_byte;
                default: shift_r        <= shift_r;
            endcase
        end
    end

    assign word       = {data_byte, shift_r};
    assign word_valid = byte_valid && (cnt_r == 2'd3);

endmodule

// File: rtl/flash_arbiter.sv
// Arbitrates the single SPI flash read engine between the instruction and
// data refill paths, round-robin on ties, and streams packed words back to
// the granted side with a four-phase req/done handshake.
module flash_arbiter #(
    parameter int ADDR_W    = flash_arb_pkg::ADDR_W,
    parameter int MAX_WORDS = flash_arb_pkg::MAX_WORDS
) (
    input  logic              CLK_CPU,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_words,
    output logic [31:0]       i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_words,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              err,
    output logic              busy,
    output logic              flash_start,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [5:0]        flash_nbytes,
    input  logic              flash_busy,
    input  logic              flash_byte_valid,
    input  logic [7:0]        flash_byte,
    input  logic              flash_done
);

    import flash_arb_pkg::*;

    localparam logic [3:0] MAX_W4 = 4'(MAX_WORDS);

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    owner_t            owner_r;
    owner_t            last_r;
    owner_t            grant_owner_s;
    logic              grant_s;
    logic              start_next_s;
    logic              err_next_s;
    logic              owner_req_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [3:0]        req_words_s;
    logic [3:0]        clamped_words_s;
    logic [3:0]        words_r;
    logic [3:0]        word_cnt_r;
    logic [ADDR_W-1:0] flash_addr_r;
    logic [5:0]        flash_nbytes_r;
    logic              flash_start_r;
    logic              busy_r;
    logic              err_r;
    logic              i_rvalid_r;
    logic              d_rvalid_r;
    logic              i_done_r;
    logic              d_done_r;
    logic [31:0]       i_rdata_r;
    logic [31:0]       d_rdata_r;
    logic [31:0]       packed_word_s;
    logic              pack_clear_s;
    logic              pack_valid_s;
    logic              word_valid_s;
    logic              all_words_s;
    logic              last_word_s;

    assign owner_req_s     = (owner_r == OWN_I) ? i_req : d_req;
    assign req_addr_s      = (grant_owner_s == OWN_I) ? i_addr : d_addr;
    assign req_words_s     = (grant_owner_s == OWN_I) ? i_words : d_words;
    assign clamped_words_s = clamp_words(req_words_s, MAX_W4);
    assign all_words_s     = (word_cnt_r == words_r);
    assign pack_clear_s    = (state_r == ISSUE);
    // Bytes past the requested length never reach the packer.
    assign pack_valid_s    = flash_byte_valid && (state_r == STREAM) && !all_words_s;
    assign last_word_s     = word_valid_s && ((word_cnt_r + 4'd1) == words_r);

    byte_packer u_packer (
        .clk        (CLK_CPU),
        .rst_n      (resetn),
        .clear      (pack_clear_s),
        .byte_valid (pack_valid_s),
        .data_byte  (flash_byte),
        .word       (packed_word_s),
        .word_valid (word_valid_s)
    );

    // Arbitration state register.
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, grant decision, command pulse and error flag.
    always_comb begin
        state_next_s  = state_r;
        grant_s       = 1'b0;
        grant_owner_s = owner_r;
        start_next_s  = 1'b0;
        err_next_s    = err_r;
        case (state_r)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_s      = 1'b1;
                    state_next_s = ISSUE;
                    start_next_s = !flash_busy;
                    if (i_req && d_req) begin
                        grant_owner_s = (last_r == OWN_I) ? OWN_D : OWN_I;
                    end else if (d_req) begin
                        grant_owner_s = OWN_D;
                    end else begin
                        grant_owner_s = OWN_I;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                // The command went out last cycle; wait for the engine if it was busy.
                if (flash_start_r) begin
                    state_next_s = STREAM;
                end else if (!flash_busy) begin
                    start_next_s = 1'b1;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            STREAM: begin
                // The engine's done ends the burst; short if words are still owed.
                if (flash_done) begin
                    state_next_s = FINISH;
                    err_next_s   = !(all_words_s || last_word_s);
                end else begin
                    state_next_s = STREAM;
                end
            end
            FINISH: begin
                if (!owner_req_s) begin
                    state_next_s = IDLE;
                    err_next_s   = 1'b0;
                end else begin
                    state_next_s = FINISH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Burst context latched at grant: owner, aligned address, clamped length.
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            owner_r        <= OWN_I;
            words_r        <= 4'd0;
            flash_addr_r   <= '0;
            flash_nbytes_r <= 6'd0;
        end else if (grant_s) begin
            owner_r        <= grant_owner_s;
            words_r        <= clamped_words_s;
            flash_addr_r   <= {req_addr_s[ADDR_W-1:2], 2'b00};
            flash_nbytes_r <= {clamped_words_s, 2'b00};
        end
    end

    // Delivered-word counter and round-robin history.
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            word_cnt_r <= 4'd0;
            last_r     <= OWN_I;
        end else begin
            if (state_r == ISSUE) begin
                word_cnt_r <= 4'd0;
            end else if (word_valid_s) begin
                word_cnt_r <= word_cnt_r + 4'd1;
            end
            if ((state_r == STREAM) && (state_next_s == FINISH)) begin
                last_r <= owner_r;
            end
        end
    end

    // Registered handshake and status outputs.
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            flash_start_r <= 1'b0;
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
            i_done_r      <= 1'b0;
            d_done_r      <= 1'b0;
        end else begin
            flash_start_r <= start_next_s;
            busy_r        <= (state_next_s != IDLE);
            err_r         <= err_next_s;
            i_done_r      <= (state_next_s == FINISH) && (owner_r == OWN_I);
            d_done_r      <= (state_next_s == FINISH) && (owner_r == OWN_D);
        end
    end

    // Registered word return to whichever side owns the burst.
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            i_rdata_r  <= 32'd0;
            d_rdata_r  <= 32'd0;
        end else begin
            i_rvalid_r <= word_valid_s && (owner_r == OWN_I);
            d_rvalid_r <= word_valid_s && (owner_r == OWN_D);
            if (word_valid_s && (owner_r == OWN_I)) begin
                i_rdata_r <= packed_word_s;
            end
            if (word_valid_s && (owner_r == OWN_D)) begin
                d_rdata_r <= packed_word_s;
            end
        end
    end

    assign i_rdata      = i_rdata_r;
    assign i_rvalid     = i_rvalid_r;
    assign i_done       = i_done_r;
    assign d_rdata      = d_rdata_r;
    assign d_rvalid     = d_rvalid_r;
    assign d_done       = d_done_r;
    assign err          = err_r;
    assign busy         = busy_r;
    assign flash_start  = flash_start_r;
    assign flash_addr   = flash_addr_r;
    assign flash_nbytes = flash_nbytes_r;

endmodule
